// File: rtl/ll_pkg.sv
// Shared definitions for the linked-list block family: opcodes, null-pointer
// computation and the walker state encoding.
package ll_pkg;

  localparam logic [2:0] LL_OP_READ         = 3'b000;
  localparam logic [2:0] LL_OP_INSERT       = 3'b001;
  localparam logic [2:0] LL_OP_DELETE_VALUE = 3'b010;
  localparam logic [2:0] LL_OP_DELETE_ADDR  = 3'b011;
  // Index-addressed variants carry bit 2.
  localparam logic [2:0] LL_OP_READ_IDX     = 3'b100;
  localparam logic [2:0] LL_OP_INSERT_IDX   = 3'b101;
  localparam logic [2:0] LL_OP_DELETE_IDX   = 3'b110;

  function automatic int addr_null(input int max_node);
    return max_node + 1;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_EMIT,
    ST_FIN
  } walker_state_e;

endpackage

// File: rtl/singly_linked_list_walker.sv
// Walks a singly linked list from its head, issuing one read per node and
// streaming each payload out as a valid/ready beat.
module singly_linked_list_walker
  import ll_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_NODE   = 8,
  localparam int ADDR_WIDTH = $clog2(MAX_NODE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] count,
  output logic [2:0]            ll_op,
  output logic [ADDR_WIDTH-1:0] ll_addr,
  output logic                  ll_op_start,
  input  logic                  ll_op_done,
  input  logic                  ll_fault,
  input  logic [DATA_WIDTH-1:0] ll_data_out,
  input  logic [ADDR_WIDTH-1:0] ll_next_node_addr,
  input  logic [ADDR_WIDTH-1:0] ll_head,
  input  logic [ADDR_WIDTH-1:0] ll_length,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH-1:0] m_index,
  output logic                  m_last
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_NULL = ADDR_WIDTH'(addr_null(MAX_NODE));
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(MAX_NODE - 1);

  // Stream handshake: a beat transfers on a cycle where m_valid and m_ready are
  // both 1; m_data/m_index/m_last stay fixed from m_valid rising until then.
  walker_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] next_q, next_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic                  last_q, last_d;
  logic                  op_start_q, op_start_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic [ADDR_WIDTH-1:0] count_inc;
  logic                  last_by_len;
  logic                  last_by_max;
  logic                  last_by_null;
  logic                  chain_short;

  assign count_inc    = count_q + 1'b1;
  assign last_by_len  = (count_inc == len_q);
  assign last_by_max  = (count_q == LAST_IDX);
  assign last_by_null = (ll_next_node_addr == ADDR_NULL);
  assign chain_short  = (count_inc < len_q);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    next_d     = next_q;
    len_d      = len_q;
    count_d    = count_q;
    err_d      = err_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    data_d     = data_q;
    index_d    = index_q;
    last_d     = last_q;
    op_start_d = op_start_q;
    addr_d     = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ptr_d   = ll_head;
          len_d   = ll_length;
          count_d = '0;
          err_d   = 1'b0;
          if (ll_length == '0) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        op_start_d = 1'b1;
        addr_d     = ptr_q;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (ll_op_done) begin
          op_start_d = 1'b0;
          if (ll_fault) begin
            err_d   = 1'b1;
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            data_d  = ll_data_out;
            next_d  = ll_next_node_addr;
            index_d = count_q;
            last_d  = last_by_len | last_by_max | last_by_null;
            // A null pointer before the advertised length means a broken chain.
            if (last_by_null && chain_short) err_d = 1'b1;
            valid_d = 1'b1;
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (m_ready) begin
          valid_d = 1'b0;
          count_d = count_inc;
          if (last_q) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            ptr_d   = next_q;
            state_d = ST_REQ;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= ADDR_NULL;
      next_q     <= ADDR_NULL;
      len_q      <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      index_q    <= '0;
      last_q     <= 1'b0;
      op_start_q <= 1'b0;
      addr_q     <= ADDR_NULL;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      next_q     <= next_d;
      len_q      <= len_d;
      count_q    <= count_d;
      err_q      <= err_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      index_q    <= index_d;
      last_q     <= last_d;
      op_start_q <= op_start_d;
      addr_q     <= addr_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign count       = count_q;
  assign ll_op       = LL_OP_READ;
  assign ll_addr     = addr_q;
  assign ll_op_start = op_start_q;
  assign m_valid     = valid_q;
  assign m_data      = data_q;
  assign m_index     = index_q;
  assign m_last      = last_q;

endmodule

// File: tb/tb_singly_linked_list_walker.sv
// Bench for singly_linked_list_walker: a list memory with a read responder, a
// traversal model built from list contents, and a per-cycle beat scoreboard.
module tb_singly_linked_list_walker;

  localparam int DW    = 8;
  localparam int MN    = 8;
  localparam int AW    = 4;
  localparam int NULLA = 9;

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] count;
  logic [2:0]    ll_op;
  logic [AW-1:0] ll_addr;
  logic          ll_op_start;
  logic          ll_op_done;
  logic          ll_fault;
  logic [DW-1:0] ll_data_out;
  logic [AW-1:0] ll_next_node_addr;
  logic [AW-1:0] ll_head;
  logic [AW-1:0] ll_length;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_index;
  logic          m_last;

  singly_linked_list_walker #(.DATA_WIDTH(DW), .MAX_NODE(MN)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .count(count), .ll_op(ll_op), .ll_addr(ll_addr), .ll_op_start(ll_op_start),
    .ll_op_done(ll_op_done), .ll_fault(ll_fault), .ll_data_out(ll_data_out),
    .ll_next_node_addr(ll_next_node_addr), .ll_head(ll_head), .ll_length(ll_length),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
    .m_last(m_last)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- list memory and bench state ----------------
  logic [DW-1:0] mem_data [16];
  logic [AW-1:0] mem_next [16];
  int tail;
  int n_nodes;
  int fault_addr = -1;
  int max_lat    = 0;
  bit stall_resp = 1'b0;
  int ready_mode = 0;
  int hold_left  = 0;

  logic [DW+AW:0] exp_q[$];
  bit exp_err;
  int exp_beats;
  int exp_ops;

  int ops_seen;
  int dones_seen;
  bit op_prev;

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks_total++;
    if (ok) checks_passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
  endtask

  // ---------------- list construction ----------------
  task automatic list_clear();
    for (int i = 0; i < 16; i++) begin
      mem_data[i] = '0;
      mem_next[i] = AW'(NULLA);
    end
    tail      = -1;
    n_nodes   = 0;
    ll_head   = AW'(NULLA);
    ll_length = '0;
  endtask

  task automatic push_back(input logic [DW-1:0] val, input int slot);
    mem_data[slot] = val;
    mem_next[slot] = AW'(NULLA);
    if (tail < 0) ll_head = AW'(slot);
    else mem_next[tail] = AW'(slot);
    tail = slot;
    n_nodes++;
    ll_length = AW'(n_nodes);
  endtask

  // ---------------- reference model: expected traversal ----------------
  task automatic build_expect();
    int  ptr;
    int  n;
    bit  lnull;
    bit  last;
    exp_q.delete();
    exp_err   = 1'b0;
    exp_beats = 0;
    exp_ops   = 0;
    if (ll_length != 0) begin
      ptr = int'(ll_head);
      n   = 0;
      forever begin
        exp_ops++;
        if (ptr == fault_addr) begin
          exp_err = 1'b1;
          break;
        end
        lnull = (int'(mem_next[ptr]) == NULLA);
        last  = lnull || (n + 1 == int'(ll_length)) || (n + 1 == MN);
        if (lnull && (n + 1 < int'(ll_length))) exp_err = 1'b1;
        exp_q.push_back({mem_data[ptr], AW'(n), last});
        n++;
        if (last) break;
        ptr = int'(mem_next[ptr]);
      end
      exp_beats = n;
    end
  endtask

  // ---------------- list read responder ----------------
  initial begin
    int wait_left;
    wait_left         = -1;
    ll_op_done        = 1'b0;
    ll_fault          = 1'b0;
    ll_data_out       = '0;
    ll_next_node_addr = '0;
    forever begin
      @(negedge clk);
      ll_op_done = 1'b0;
      ll_fault   = 1'b0;
      if (rst || !ll_op_start || stall_resp) begin
        wait_left = -1;
      end else begin
        if (wait_left < 0) wait_left = $urandom_range(0, max_lat);
        if (wait_left == 0) begin
          ll_op_done        = 1'b1;
          ll_fault          = (int'(ll_addr) == fault_addr);
          ll_data_out       = mem_data[ll_addr];
          ll_next_node_addr = mem_next[ll_addr];
          wait_left         = -1;
        end else begin
          wait_left--;
        end
      end
    end
  end

  // ---------------- scoreboard and m_ready driver ----------------
  initial begin
    m_ready = 1'b0;
    op_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        op_prev = 1'b0;
      end else begin
        if (ll_op_start && !op_prev) ops_seen++;
        op_prev = ll_op_start;
        if (done) dones_seen++;
        if (m_valid) begin
          check(!ll_op_start, "op_during_beat", 32'(ll_op_start), 32'd0);
          if (exp_q.size() == 0)
            check(1'b0, "unexpected_beat", {m_data, m_index, m_last}, 32'd0);
          else
            check({m_data, m_index, m_last} == exp_q[0], "beat",
                  {m_data, m_index, m_last}, exp_q[0]);
        end
        case (ready_mode)
          1: m_ready = 1'($urandom_range(0, 1));
          2: begin
            if (m_valid && m_index == 4'd1 && hold_left > 0) begin
              m_ready = 1'b0;
              hold_left--;
            end else begin
              m_ready = 1'b1;
            end
          end
          default: m_ready = 1'b1;
        endcase
        if (m_valid && m_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- traversal driver ----------------
  task automatic run_trav(input string name, input int max_cycles, input bit poke,
                          output int cyc);
    build_expect();
    ops_seen   = 0;
    dones_seen = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      start = poke && (cyc == 3);
    end
    start = 1'b0;
    check(cyc < max_cycles, {name, "_timeout"}, 32'(cyc), 32'(max_cycles));
    check(err == exp_err, {name, "_err"}, 32'(err), 32'(exp_err));
    check(int'(count) == exp_beats, {name, "_count"}, 32'(count), 32'(exp_beats));
    check(exp_q.size() == 0, {name, "_beats_left"}, 32'(exp_q.size()), 32'd0);
    check(ops_seen == exp_ops, {name, "_reads"}, 32'(ops_seen), 32'(exp_ops));
    @(negedge clk);
    check(dones_seen == 1, {name, "_done_pulses"}, 32'(dones_seen), 32'd1);
    check(!done && !busy, {name, "_back_idle"}, {30'd0, done, busy}, 32'd0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int slots[9];
    int n;
    int kind;
    int pick;
    logic [DW+AW:0] pin;

    rst   = 1'b1;
    start = 1'b0;
    list_clear();
    repeat (3) @(negedge clk);
    check(!busy && !done && !err && !m_valid && !m_last && !ll_op_start,
          "reset_flags", {26'd0, busy, done, err, m_valid, m_last, ll_op_start}, 32'd0);
    check(count == 4'd0 && m_data == 8'd0 && m_index == 4'd0, "reset_data",
          {count, m_data, m_index}, 32'd0);
    check(ll_addr == 4'd9, "reset_ll_addr", 32'(ll_addr), 32'd9);
    check(ll_op == 3'b000, "reset_ll_op", 32'(ll_op), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Empty list.
    list_clear();
    run_trav("empty", 20, 1'b0, cyc);
    check(cyc <= 2, "empty_latency", 32'(cyc), 32'd2);

    // Three-node list, always ready; pin the model with hand-computed beats.
    list_clear();
    push_back(8'hA1, 0);
    push_back(8'hA2, 1);
    push_back(8'hA3, 2);
    build_expect();
    check(exp_q.size() == 3, "model_size", 32'(exp_q.size()), 32'd3);
    pin = {8'hA1, 4'd0, 1'b0};
    check(exp_q[0] == pin, "model_beat0", exp_q[0], pin);
    pin = {8'hA3, 4'd2, 1'b1};
    check(exp_q[2] == pin, "model_beat2", exp_q[2], pin);
    ready_mode = 0;
    max_lat    = 2;
    run_trav("three", 200, 1'b0, cyc);
    check(count == 4'd3 && !err, "three_literal", {count, err}, {4'd3, 1'b0});

    // Backpressure on beat 1, with a stray start while busy.
    ready_mode = 2;
    hold_left  = 5;
    run_trav("hold", 200, 1'b1, cyc);
    check(hold_left == 0, "hold_applied", 32'(hold_left), 32'd0);
    ready_mode = 0;

    // Fault on the read of node 1.
    fault_addr = 1;
    run_trav("fault", 200, 1'b0, cyc);
    check(count == 4'd1 && err, "fault_literal", {count, err}, {4'd1, 1'b1});
    fault_addr = -1;

    // Length 3 but node 1 terminates the chain.
    mem_next[1] = AW'(NULLA);
    run_trav("broken", 200, 1'b0, cyc);
    check(count == 4'd2 && err, "broken_literal", {count, err}, {4'd2, 1'b1});
    mem_next[1] = 4'd2;

    // Reset while a read is outstanding.
    stall_resp = 1'b1;
    exp_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (!ll_op_start && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check(ll_op_start, "rst_wait_reached", 32'(ll_op_start), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check(!ll_op_start && !busy && !m_valid && !done, "rst_in_wait",
          {28'd0, ll_op_start, busy, m_valid, done}, 32'd0);
    rst        = 1'b0;
    stall_resp = 1'b0;
    repeat (3) @(negedge clk);
    check(!busy && !done, "rst_stays_idle", {30'd0, busy, done}, 32'd0);
    run_trav("after_rst", 200, 1'b0, cyc);

    // Randomized traversals.
    for (int t = 0; t < 30; t++) begin
      list_clear();
      for (int i = 0; i < 9; i++) slots[i] = i;
      for (int i = 8; i > 0; i--) begin
        pick        = $urandom_range(0, i);
        n           = slots[i];
        slots[i]    = slots[pick];
        slots[pick] = n;
      end
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) push_back(8'($urandom_range(0, 255)), slots[i]);
      kind = $urandom_range(0, 9);
      case (kind)
        0: begin
          mem_next[tail] = ll_head;
          ll_length      = AW'($urandom_range(n, 15));
        end
        1: ll_length = AW'($urandom_range(1, 15));
        2: fault_addr = slots[$urandom_range(0, n - 1)];
        3: ll_length = '0;
        default: ;
      endcase
      ready_mode = $urandom_range(0, 1);
      max_lat    = $urandom_range(0, 3);
      run_trav("rand", 600, 1'($urandom_range(0, 1)), cyc);
      fault_addr = -1;
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/singly_linked_list_walker.md
SINGLY_LINKED_LIST_WALKER -- requirements
Module: singly_linked_list_walker

Interface
REQ-001 The block SHALL have one clock, clk, and one reset, rst; rst SHALL be synchronous and active-high.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the node payload width.
REQ-003 Parameter MAX_NODE, default 8, SHALL set the list capacity.
REQ-004 Derived constants SHALL be ADDR_WIDTH = clog2(MAX_NODE+1) and ADDR_NULL = MAX_NODE+1.
REQ-005 Ports SHALL be, as name / direction / width / meaning:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin traversal from head
- busy  out  1  traversal in progress
- done  out  1  one-cycle end-of-traversal pulse
- err  out  1  traversal error; held until next accepted start
- count  out  ADDR_WIDTH  beats emitted in current or last traversal
- ll_op  out  3  list opcode; constant 3'b000 (read by address)
- ll_addr  out  ADDR_WIDTH  node address to read
- ll_op_start  out  1  list operation request
- ll_op_done  in  1  list operation complete
- ll_fault  in  1  list fault, qualified by ll_op_done
- ll_data_out  in  DATA_WIDTH  read payload
- ll_next_node_addr  in  ADDR_WIDTH  read next pointer
- ll_head  in  ADDR_WIDTH  list head address
- ll_length  in  ADDR_WIDTH  list node count
- m_valid  out  1  stream beat valid
- m_ready  in  1  stream beat accept
- m_data  out  DATA_WIDTH  node payload
- m_index  out  ADDR_WIDTH  position from head, 0-based
- m_last  out  1  final beat of traversal

Function
REQ-006 FSM states SHALL be IDLE, REQ, WAIT, EMIT and FIN.
REQ-007 IDLE: start=1 SHALL snapshot ll_head and ll_length, clear count and err, and move to FIN if the length snapshot is 0; otherwise it SHALL move to REQ.
REQ-008 start SHALL be ignored outside IDLE.
REQ-009 REQ: ll_op_start SHALL be registered high with ll_addr equal to the current pointer; the FSM SHALL then move to WAIT.
REQ-010 WAIT: ll_op_start, ll_op and ll_addr SHALL be held stable until ll_op_done=1 is sampled.
- ll_op_start SHALL be low in the cycle after that sample.
REQ-011 WAIT with ll_op_done=1 and ll_fault=1 SHALL set err and move to FIN; no beat is emitted.
REQ-012 WAIT with ll_op_done=1 and ll_fault=0 SHALL:
- capture ll_data_out into m_data and ll_next_node_addr as the next pointer;
- set m_index to count;
- set m_last to 1 if count == length_snapshot-1 or ll_next_node_addr == ADDR_NULL;
- move to EMIT.
REQ-013 EMIT: m_valid SHALL be 1, and m_data, m_index and m_last SHALL be stable until m_valid&m_ready.
REQ-014 On acceptance, count SHALL increment.
- If m_last=1, the FSM SHALL move to FIN.
- Otherwise the pointer SHALL take the captured next pointer and the FSM SHALL move to REQ.
REQ-015 A broken chain, meaning m_last set by ADDR_NULL while count < length_snapshot-1, SHALL set err.
REQ-016 FIN SHALL pulse done for exactly one cycle and then return to IDLE.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 At most one list operation SHALL be outstanding; the next read SHALL NOT issue before the current beat is accepted.
REQ-019 count SHALL never exceed MAX_NODE; a traversal reaching MAX_NODE beats SHALL force m_last.
REQ-020 Minimum per-node latency SHALL be list read latency + 1 cycle from ll_op_done to m_valid.

Reset
REQ-021 With rst=1 at a clk edge:
- state SHALL become IDLE;
- busy, done, err, m_valid, m_last and ll_op_start SHALL become 0;
- count, m_data and m_index SHALL become 0;
- ll_addr SHALL become ADDR_NULL;
- ll_op SHALL become 3'b000.
REQ-022 Reset mid-traversal SHALL abandon the traversal with no done pulse; ll_op_start SHALL be low from the cycle after reset.

Structure
REQ-023 A shared package ll_pkg SHALL hold the list opcode constants (READ=0, INSERT=1, DELETE_VALUE=2, DELETE_ADDR=3, index variants with bit 2 set), the ADDR_NULL computation and the walker state enum.
REQ-024 The block SHALL be a single module with no sub-modules.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Empty list (ll_length=0), start -> done within 2 cycles; count=0; no ll_op_start; no m_valid.
- Three push_backs of 0xA1, 0xA2, 0xA3 into the list, then start with m_ready=1 -> beats 0xA1, 0xA2, 0xA3 with m_index 0, 1, 2; m_last only on the third; count=3; err=0.
- Same list with m_ready low for 5 cycles on beat 1 -> m_data=0xA2 stable throughout; no ll_op_start until acceptance.
- Read with ll_fault=1 on node 1 -> one beat (0xA1), then done; err=1; count=1.
- ll_length=3 with node 1 next=ADDR_NULL -> two beats, m_last on the second, err=1.
- rst asserted in WAIT -> next cycle ll_op_start=0, busy=0, m_valid=0, no done; a subsequent start traverses normally.
